// File: rtl/struct_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: op encoding,
// request/response bundles, sequencer states and decode constants.
package struct_pkg;

  // Decode generates start when opcode/funct7 match these values.
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Op select, encoded exactly as funct3.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_e;

  typedef struct packed {
    muldiv_op_e  op;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
  } muldiv_in_t;

  typedef struct packed {
    logic        done;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] result;
  } muldiv_out_t;

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV and REM.
  function automatic logic op_signed_b(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: a shift-add multiply step or a
// restoring-divide step, selected by is_div. Purely combinational.
//   multiply: acc = {partial high, multiplier being shifted out}, m = multiplicand
//   divide:   acc[31:0] = dividend shifting into quotient, rem = partial remainder,
//             m = divisor
module muldiv_step
  import struct_pkg::*;
(
  input  logic        is_div,
  input  logic [63:0] acc_i,
  input  logic [32:0] rem_i,
  input  logic [31:0] m_i,
  output logic [63:0] acc_o,
  output logic [32:0] rem_o
);

  logic [32:0] sum;
  logic [33:0] rem_sh;
  logic        ge;

  // Compute both step flavours, then pick the one for the current op.
  always_comb begin
    sum    = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, m_i} : 33'd0);
    rem_sh = {rem_i, acc_i[31]};
    ge     = (rem_sh >= {2'b00, m_i});
    acc_o  = acc_i;
    rem_o  = rem_i;
    if (is_div) begin
      acc_o = {acc_i[63:32], acc_i[30:0], ge};
      rem_o = ge ? 33'(rem_sh - {2'b00, m_i}) : rem_sh[32:0];
    end else begin
      acc_o = {sum, acc_i[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer for the EX stage.
// Handshake: EX raises start with operands for one cycle in IDLE; stall is
// high combinationally from that cycle until the op completes, so EX keeps
// presenting the op; done pulses for one cycle (DONE state) with result and
// rd_out valid, and stall drops that cycle so EX/MEM captures the result.
// flush aborts any op in flight without a done pulse.
module muldiv_seq
  import struct_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            regWrite_out,
  output logic [1:0]      dbg_state
);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q, op_d;
  logic [4:0]    cnt_q, cnt_d, rd_q, rd_d;
  logic [63:0]   acc_q, acc_d, step_acc;
  logic [32:0]   rem_q, rem_d, step_rem;
  logic [31:0]   m_q, m_d, spec_val_q, spec_val_d, result_q, result_d;
  logic          neg_q, neg_d, spec_q, spec_d;

  muldiv_in_t  req;
  muldiv_out_t rsp;
  logic        accept, sa_in, sb_in, spec_in, is_div_in;
  logic [31:0] a_mag, b_mag, spec_val_in, fixed;
  logic [63:0] prod;

  assign req.op = muldiv_op_e'(funct3);
  assign req.rd = rd_in;
  assign req.a  = A;
  assign req.b  = B;

  // Decode the incoming request: magnitudes, result sign and fast-path cases.
  always_comb begin
    accept    = (state_q == MD_IDLE) && start && !flush;
    is_div_in = req.op[2];
    sa_in     = op_signed_a(req.op) && req.a[31];
    sb_in     = op_signed_b(req.op) && req.b[31];
    a_mag     = sa_in ? -req.a : req.a;
    b_mag     = sb_in ? -req.b : req.b;
    spec_in   = 1'b0;
    spec_val_in = 32'd0;
    if (is_div_in && (req.b == 32'd0)) begin
      spec_in     = 1'b1;
      spec_val_in = req.op[1] ? req.a : 32'hFFFF_FFFF;
    end else if (((req.op == OP_DIV) || (req.op == OP_REM)) &&
                 (req.a == 32'h8000_0000) && (req.b == 32'hFFFF_FFFF)) begin
      spec_in     = 1'b1;
      spec_val_in = req.op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  muldiv_step u_step (
    .is_div (op_q[2]),
    .acc_i  (acc_q),
    .rem_i  (rem_q),
    .m_i    (m_q),
    .acc_o  (step_acc),
    .rem_o  (step_rem)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> CALC (or DONE on fast path) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept) state_d = spec_in ? MD_DONE : MD_CALC;
      MD_CALC: begin
        if (flush)                         state_d = MD_IDLE;
        else if (cnt_q == 5'(ITER - 1))    state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Sign fix-up and result selection for the DONE cycle.
  always_comb begin
    prod  = neg_q ? -acc_q : acc_q;
    fixed = 32'd0;
    case (op_q)
      OP_MUL:                         fixed = prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   fixed = prod[63:32];
      OP_DIV, OP_DIVU:                fixed = neg_q ? -acc_q[31:0] : acc_q[31:0];
      OP_REM, OP_REMU:                fixed = neg_q ? -rem_q[31:0] : rem_q[31:0];
    endcase
    if (spec_q) fixed = spec_val_q;
  end

  // FSM outputs.
  always_comb begin
    stall         = accept || (state_q == MD_CALC);
    busy          = (state_q != MD_IDLE);
    rsp.done      = (state_q == MD_DONE) && !flush;
    rsp.reg_write = rsp.done && (rd_q != 5'd0);
    rsp.rd        = rd_q;
    rsp.result    = (state_q == MD_DONE) ? fixed : result_q;
    done          = rsp.done;
    regWrite_out  = rsp.reg_write;
    rd_out        = rsp.rd;
    result        = rsp.result;
    dbg_state     = state_q;
  end

  // Datapath next values: latch on accept, iterate in CALC, hold result in DONE.
  always_comb begin
    op_d       = op_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    m_d        = m_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    result_d   = result_q;
    if (accept) begin
      op_d       = req.op;
      rd_d       = req.rd;
      cnt_d      = 5'd0;
      acc_d      = {32'd0, is_div_in ? a_mag : b_mag};
      rem_d      = 33'd0;
      m_d        = is_div_in ? b_mag : a_mag;
      neg_d      = (req.op == OP_REM || req.op == OP_REMU) ? sa_in : (sa_in ^ sb_in);
      spec_d     = spec_in;
      spec_val_d = spec_val_in;
    end
    if (state_q == MD_CALC) begin
      acc_d = step_acc;
      rem_d = step_rem;
      cnt_d = cnt_q + 5'd1;
    end
    if ((state_q == MD_DONE) && !flush) result_d = fixed;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_MUL;
      rd_q       <= 5'd0;
      cnt_q      <= 5'd0;
      acc_q      <= 64'd0;
      rem_q      <= 33'd0;
      m_q        <= 32'd0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'd0;
      result_q   <= 32'd0;
    end else begin
      op_q       <= op_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      m_q        <= m_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, randomized ops checked against
// an arithmetic reference model, and hand sequences for flush/reset corners.
module tb_muldiv_seq;

  logic        clk, rst_n, start, flush;
  logic [2:0]  funct3;
  logic [31:0] A, B, result;
  logic [4:0]  rd_in, rd_out;
  logic        stall, busy, done, regWrite_out;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .A(A), .B(B),
    .rd_in(rd_in), .flush(flush), .stall(stall), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out), .regWrite_out(regWrite_out),
    .dbg_state(dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: RV32M semantics computed with wide plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, ub;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = a;
    ib = b;
    case (op)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op in cycle 0 and watch cycles 1..36 for done, stall and busy.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_cyc);
    int done_cyc = -1;
    int ndone = 0;
    logic [31:0] res = 32'd0;
    logic        rw = 1'b0;
    logic [4:0]  rdo = 5'd0;
    logic        prof_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; funct3 = op; A = a; B = b; rd_in = rd;
    @(negedge clk);
    if (stall !== 1'b1) prof_ok = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; rd_in = 5'($urandom);
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = c; res = result; rw = regWrite_out; rdo = rd_out;
        end
      end
      if (stall !== (c < exp_cyc)) prof_ok = 1'b0;
      if (busy !== (c <= exp_cyc)) prof_ok = 1'b0;
    end
    chk({name, " done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
    chk({name, " done_count"}, 32'(ndone), 32'd1);
    chk({name, " result"}, res, exp);
    chk({name, " rd_out"}, {27'd0, rdo}, {27'd0, rd});
    chk({name, " regwrite"}, {31'd0, rw}, {31'd0, (rd != 5'd0)});
    chk({name, " stall_busy_profile"}, {31'd0, prof_ok}, 32'd1);
  endtask

  initial begin
    int ndone;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'b000, 32'd7,          32'd6,          5'd3,  32'h0000_002A, 33};
    vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000,  5'd4,  32'h4000_0000, 33};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5,  32'hFFFF_FFFE, 33};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'h0000_0002,  5'd6,  32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'b000, 32'd3,          32'd5,          5'd0,  32'd15,        33};
    vecs[7]  = '{3'b100, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF, 1};
    vecs[8]  = '{3'b111, 32'd5,          32'd0,          5'd11, 32'd5,         1};
    vecs[9]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000, 1};
    vecs[10] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,         1};
    vecs[11] = '{3'b111, 32'd100,        32'd7,          5'd14, 32'd2,         33};
    vecs[12] = '{3'b101, 32'd100,        32'd7,          5'd9,  32'd14,        33};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0;
    A = 32'd0; B = 32'd0; rd_in = 5'd0;
    #3;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd_out", {27'd0, rd_out}, 32'd0);
    chk("reset regwrite", {31'd0, regWrite_out}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    #20 rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp, vecs[i].cyc);

    // Asynchronous reset in cycle 20 of a multiply
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b000; A = 32'd3; B = 32'd4; rd_in = 5'd6;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 2; c <= 20; c++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midop_reset busy", {31'd0, busy}, 32'd0);
    chk("midop_reset done", {31'd0, done}, 32'd0);
    chk("midop_reset result", result, 32'd0);
    chk("midop_reset rd_out", {27'd0, rd_out}, 32'd0);
    chk("midop_reset stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("midop_reset no_done", 32'(ndone), 32'd0);

    // Flush in cycle 10 of a DIV, then a fresh op issued in cycle 12
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b100; A = 32'd1000; B = 32'd3; rd_in = 5'd5;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    if (done === 1'b1) ndone++;
    chk("flush_calc busy_c10", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    if (done === 1'b1) ndone++;
    chk("flush_calc busy_c11", {31'd0, busy}, 32'd0);
    chk("flush_calc stall_c11", {31'd0, stall}, 32'd0);
    chk("flush_calc no_done", 32'(ndone), 32'd0);
    run_op("after_flush", 3'b100, 32'd1000, 32'd3, 5'd5, 32'd333, 33);

    // start together with flush in IDLE is not accepted
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; A = 32'd2; B = 32'd2; rd_in = 5'd1;
    @(negedge clk);
    chk("start_flush stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("start_flush busy", {31'd0, busy}, 32'd0);

    // Flush landing on the DONE cycle of a fast-path op suppresses done
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b100; A = 32'd5; B = 32'd0; rd_in = 5'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_done done", {31'd0, done}, 32'd0);
    chk("flush_done regwrite", {31'd0, regWrite_out}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_done busy", {31'd0, busy}, 32'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = rand_operand();
      rb  = rand_operand();
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 5'($urandom),
             ref_result(rop, ra, rb), ref_latency(rop, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle sequencer for RV32M multiply/divide ops issued from the EX stage of the 5-stage pipeline. It accepts one op with its operands, runs an iterative 32-step shift-add multiply or restoring divide, and holds the pipeline through `stall` until the result is ready. It returns the result with the destination register so EX/MEM can capture it like a normal ALU result.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.
- ITER, 32, number of CALC iterations. Must equal XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  issue request from EX; valid only when the op is an M-extension op.
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A  in  32  rs1 operand (already forwarded).
- B  in  32  rs2 operand (already forwarded).
- rd_in  in  5  destination register.
- flush  in  1  pipeline flush (branch/jump redirect).
- stall  out  1  hold IF/ID/EX.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse; result valid.
- result  out  32  op result.
- rd_out  out  5  latched destination register.
- regWrite_out  out  1  equals done and (rd_out != 0).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, busy=0, done=0, result=0, rd_out=0, regWrite_out=0, all internal accumulators 0. Reset mid-operation aborts the op with no done pulse.
- States are IDLE, CALC and DONE.
- Cycle numbering: cycle 0 is the IDLE cycle in which start=1 is sampled.
- IDLE:
  - On start=1 and flush=0: latch funct3, rd_in, |A| and |B| (magnitudes per signedness), and the result sign.
  - Next state is CALC with counter=0, or DONE directly on a special case.
  - start=1 with flush=1 in the same cycle: flush wins, the op is not accepted.
- Signedness:
  - MUL and MULH: A and B signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - Multiply product sign = sA xor sB.
  - Quotient sign = sA xor sB; remainder sign = sA.
- CALC, multiply: one step per cycle; shift-add into a 64-bit product register.
- CALC, divide: restoring divide; one quotient bit per cycle; 33-bit partial remainder.
- Counter increments each CALC cycle; after the 32nd CALC cycle (counter=31) go to DONE.
- DONE (one cycle):
  - Apply two's-complement sign fix-up.
  - Drive result: MUL gives product[31:0]; MULH, MULHSU and MULHU give product[63:32]; DIV/DIVU give quotient; REM/REMU give remainder.
  - done=1 for exactly this cycle, then return to IDLE.
  - A start in the DONE cycle is ignored; EX presents it again.
- Latency: normal op has done=1 in cycle 33; special case has done=1 in cycle 1.
- Special cases (fast path, bypass CALC):
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM): DIV gives 0x80000000, REM gives 0.
- stall = (state==IDLE and start and !flush) or state==CALC. Combinational, so it is high in cycle 0. It is low in DONE so the pipeline advances and captures result.
- start while in CALC is ignored (no re-latch).
- flush in CALC or DONE: synchronous abort to IDLE on the next edge. If flush arrives in DONE, done is forced to 0 that cycle. No result is written.
- result and rd_out hold their last values outside DONE; consumers qualify them with done.

Decomposition:
- Add to struct_pkg:
  - enum muldiv_op_e, encoded as funct3.
  - struct muldiv_in with op, rd, A, B.
  - struct muldiv_out with done, regWrite, rd, result.
  - localparam OPCODE_OP=7'b0110011 and FUNCT7_MULDIV=7'b0000001, used by decode to generate start.
- One natural sub-module: muldiv_step, a combinational single-iteration shift-add/restore-subtract cell. The FSM, counter and sign handling stay in muldiv_seq.

Test Plan:
- MUL A=7, B=6, start in cycle 0 → stall=1 in cycles 0–32; done=1 in cycle 33 only; result=0x0000002A; rd_out=rd_in.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; all with done in cycle 33.
- DIV 5/0 → 0xFFFFFFFF with done in cycle 1; REMU 5/0 → 5; DIV 0x80000000/−1 → 0x80000000; REM → 0, each with done in cycle 1.
- flush in cycle 10 of a DIV → busy=0 and stall=0 from cycle 11, no done pulse. Next start in cycle 12 completes normally in cycle 45.
- rst_n low in cycle 20 → busy, done and result are 0 immediately (asynchronous). rd=0 op → done=1 with regWrite_out=0.
